// File: rtl/fifo_mult_sequencer_pkg.sv
// rtl/fifo_mult_sequencer_pkg.sv - opcodes, FSM states and default widths for the FIFO multiplier sequencer
package fifo_seq_pkg;

  localparam int DATA_W = 256;
  localparam int OP_W   = 2;
  localparam int CNT_W  = 32;

  localparam logic [OP_W-1:0] OP_NOP = 2'd0;
  localparam logic [OP_W-1:0] OP_MUL = 2'd1;
  localparam logic [OP_W-1:0] OP_SQR = 2'd2;
  localparam logic [OP_W-1:0] OP_RSV = 2'd3;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_CMD_WAIT  = 3'd1,
    ST_OPS_REQ   = 3'd2,
    ST_OPS_WAIT  = 3'd3,
    ST_START     = 3'd4,
    ST_WAIT_DONE = 3'd5,
    ST_PUSH      = 3'd6
  } seq_state_t;

  // Only MUL and SQR launch the multiplier; everything else retires without touching A/B/C.
  function automatic logic op_launches(input logic [OP_W-1:0] op);
    return (op == OP_MUL) || (op == OP_SQR);
  endfunction

endpackage

// File: rtl/fifo_mult_sequencer_if.sv
// rtl/fifo_mult_sequencer_if.sv - FIFO A/B/C/D and multiplier handshake bundle for the sequencer
interface fifo_mult_sequencer_if #(
  parameter int DATA_W = 256
) ();

  logic              fifo_d_empty;
  logic              fifo_d_rd_en;
  logic [DATA_W-1:0] fifo_d_data;

  logic              fifo_a_empty;
  logic              fifo_a_rd_en;
  logic [DATA_W-1:0] fifo_a_data;

  logic              fifo_b_empty;
  logic              fifo_b_rd_en;
  logic [DATA_W-1:0] fifo_b_data;

  logic              fifo_c_full;
  logic              fifo_c_wr_en;
  logic [DATA_W-1:0] fifo_c_data;

  logic              mul_start;
  logic [DATA_W-1:0] mul_op_a;
  logic [DATA_W-1:0] mul_op_b;
  logic              mul_done;
  logic [DATA_W-1:0] mul_result;

  // master: the sequencer; slave: FIFO block plus multiplier core
  modport master (
    input  fifo_d_empty, fifo_d_data,
    input  fifo_a_empty, fifo_a_data,
    input  fifo_b_empty, fifo_b_data,
    input  fifo_c_full,
    input  mul_done, mul_result,
    output fifo_d_rd_en, fifo_a_rd_en, fifo_b_rd_en,
    output fifo_c_wr_en, fifo_c_data,
    output mul_start, mul_op_a, mul_op_b
  );

  modport slave (
    output fifo_d_empty, fifo_d_data,
    output fifo_a_empty, fifo_a_data,
    output fifo_b_empty, fifo_b_data,
    output fifo_c_full,
    output mul_done, mul_result,
    input  fifo_d_rd_en, fifo_a_rd_en, fifo_b_rd_en,
    input  fifo_c_wr_en, fifo_c_data,
    input  mul_start, mul_op_a, mul_op_b
  );

endinterface

// File: rtl/fifo_mult_sequencer.sv
// rtl/fifo_mult_sequencer.sv - pops D/A/B, runs the multiplier, pushes C; FIFO_SEQ_PERF_CNT_EN adds op_count
module fifo_mult_sequencer
  import fifo_seq_pkg::*;
#(
  parameter int Data = DATA_W,
  parameter int OPW  = OP_W,
  parameter int CNTW = CNT_W
) (
  input  logic                  clk,
  input  logic                  rst_n,
  fifo_mult_sequencer_if.master bus,
  output logic                  busy,
  output logic                  bad_op
`ifdef FIFO_SEQ_PERF_CNT_EN
  ,
  output logic [CNTW-1:0]       op_count
`endif
);

  seq_state_t r_state;
  seq_state_t w_state_nxt;

  logic            r_is_mul;
  logic            r_bad_op;
  logic [Data-1:0] r_op_a;
  logic [Data-1:0] r_op_b;
  logic [Data-1:0] r_result;

  logic            w_d_rd;
  logic            w_a_rd;
  logic            w_b_rd;
  logic            w_c_wr;
  logic            w_start;
  logic            w_ops_ready;
  logic [OPW-1:0]  w_opcode;
  logic            w_unused_cmd;

  assign w_opcode     = bus.fifo_d_data[OPW-1:0];
  assign w_unused_cmd = ^bus.fifo_d_data[Data-1:OPW];
  assign w_ops_ready  = !bus.fifo_a_empty && (!r_is_mul || !bus.fifo_b_empty);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_d_rd      = 1'b0;
    w_a_rd      = 1'b0;
    w_b_rd      = 1'b0;
    w_c_wr      = 1'b0;
    w_start     = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (!bus.fifo_d_empty) begin
          w_d_rd      = 1'b1;
          w_state_nxt = ST_CMD_WAIT;
        end
      end
      ST_CMD_WAIT: begin
        w_state_nxt = op_launches(w_opcode) ? ST_OPS_REQ : ST_IDLE;
      end
      ST_OPS_REQ: begin
        if (w_ops_ready) begin
          w_a_rd      = 1'b1;
          w_b_rd      = r_is_mul;
          w_state_nxt = ST_OPS_WAIT;
        end
      end
      ST_OPS_WAIT: begin
        w_state_nxt = ST_START;
      end
      ST_START: begin
        w_start     = 1'b1;
        w_state_nxt = ST_WAIT_DONE;
      end
      ST_WAIT_DONE: begin
        if (bus.mul_done) begin
          w_state_nxt = ST_PUSH;
        end
      end
      ST_PUSH: begin
        if (!bus.fifo_c_full) begin
          w_c_wr      = 1'b1;
          w_state_nxt = ST_IDLE;
        end
      end
      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_is_mul <= 1'b0;
      r_bad_op <= 1'b0;
      r_op_a   <= '0;
      r_op_b   <= '0;
      r_result <= '0;
    end else begin
      if (r_state == ST_CMD_WAIT) begin
        r_is_mul <= (w_opcode == OP_MUL);
        if (w_opcode == OP_RSV) begin
          r_bad_op <= 1'b1;
        end
      end
      // SQR feeds operand A to both multiplier inputs
      if (r_state == ST_OPS_WAIT) begin
        r_op_a <= bus.fifo_a_data;
        r_op_b <= r_is_mul ? bus.fifo_b_data : bus.fifo_a_data;
      end
      if ((r_state == ST_WAIT_DONE) && bus.mul_done) begin
        r_result <= bus.mul_result;
      end
    end
  end

`ifdef FIFO_SEQ_PERF_CNT_EN
  logic [CNTW-1:0] r_op_count;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_op_count <= '0;
    end else if (w_c_wr) begin
      r_op_count <= r_op_count + CNTW'(1);
    end
  end

  assign op_count = r_op_count;
`endif

  // The D pop is the only strobe reachable from IDLE; hold it low while reset is asserted.
  assign bus.fifo_d_rd_en = w_d_rd & rst_n;
  assign bus.fifo_a_rd_en = w_a_rd;
  assign bus.fifo_b_rd_en = w_b_rd;
  assign bus.fifo_c_wr_en = w_c_wr;
  assign bus.fifo_c_data  = r_result;
  assign bus.mul_start    = w_start;
  assign bus.mul_op_a     = r_op_a;
  assign bus.mul_op_b     = r_op_b;

  assign busy   = (r_state != ST_IDLE);
  assign bad_op = r_bad_op;

endmodule
